baser_257b_decoder: RTL

Receive-side 256b/257b reverse transcoder for the BASE-R path. It accepts one 257-bit transcoded block and expands it into four 66-bit 64b/66b blocks, emitted one per cycle. It sits downstream of the descrambler, at the opposite end of the link from the generator's transcoder, and feeds 64b/66b decode and the block checkers. Malformed transcoded blocks are replaced with error control blocks and counted.

---
 rtl/baser_pkg.sv | 45 ++++
 rtl/baser_257b_unpack.sv | 58 +++++
 rtl/baser_257b_decoder.sv | 93 +++++++++
 3 files changed

// File: rtl/baser_pkg.sv
// Shared BASE-R definitions: sync headers, block types, error block, decoder FSM states
// and the control-type nibble restore function used by the 256b/257b reverse transcoder.
package baser_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam logic [6:0] CC_ERR  = 7'h1E;

  // Control block carrying eight /E/ characters
  localparam logic [65:0] ERR_BLOCK = {{8{CC_ERR}}, BT_IDLE, SH_CTRL};

  typedef enum logic [2:0] {
    IDLE,
    OUT0,
    OUT1,
    OUT2,
    OUT3
  } state_t;

  function automatic logic [7:0] restore_type(input logic [3:0] hi);
    logic [7:0] bt;
    case (hi)
      4'h1:    bt = 8'h1E;
      4'h2:    bt = 8'h2D;
      4'h3:    bt = 8'h33;
      4'h4:    bt = 8'h4B;
      4'h5:    bt = 8'h55;
      4'h6:    bt = 8'h66;
      4'h7:    bt = 8'h78;
      4'h8:    bt = 8'h87;
      4'h9:    bt = 8'h99;
      4'hA:    bt = 8'hAA;
      4'hB:    bt = 8'hB4;
      4'hC:    bt = 8'hCC;
      4'hD:    bt = 8'hD2;
      4'hE:    bt = 8'hE1;
      4'hF:    bt = 8'hFF;
      default: bt = 8'h00;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/baser_257b_unpack.sv
// Combinational 257b -> 4x66b expansion with malformed-block detection.
// Error-block substitution is left to the caller.
module baser_257b_unpack
  import baser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int TC_WIDTH   = 257
) (
  input  logic [TC_WIDTH-1:0]                      coded,
  output logic [3:0][DATA_WIDTH+HDR_WIDTH-1:0]     blocks,
  output logic                                     inv
);

  // Zero-extended so every constant slice below stays in range
  logic [TC_WIDTH+DATA_WIDTH-1:0] ext;
  logic [3:0]                     mask;
  logic [3:0]                     hi;
  logic [7:0]                     rt;
  int unsigned                    first_ctrl;

  assign ext  = {{DATA_WIDTH{1'b0}}, coded};
  assign mask = coded[4:1];

  always_comb begin
    casez (mask)
      4'b???0: first_ctrl = 0;
      4'b??01: first_ctrl = 1;
      4'b?011: first_ctrl = 2;
      4'b0111: first_ctrl = 3;
      default: first_ctrl = 4;
    endcase
  end

  // Blocks before the first control block sit 4 bits higher (after the mask);
  // the first control block drops its type low nibble, realigning the rest to 1+64k.
  always_comb begin
    blocks = '0;
    hi     = '0;
    rt     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (coded[0]) begin
        blocks[k] = {ext[1+DATA_WIDTH*k +: DATA_WIDTH], SH_DATA};
      end else if (k < first_ctrl) begin
        blocks[k] = {ext[5+DATA_WIDTH*k +: DATA_WIDTH], SH_DATA};
      end else if (k == first_ctrl) begin
        hi        = ext[5+DATA_WIDTH*k +: 4];
        rt        = restore_type(hi);
        blocks[k] = {ext[9+DATA_WIDTH*k +: DATA_WIDTH-8], rt, SH_CTRL};
      end else begin
        blocks[k] = {ext[1+DATA_WIDTH*k +: DATA_WIDTH], mask[k] ? SH_DATA : SH_CTRL};
      end
    end
  end

  assign inv = !coded[0] && ((first_ctrl == 4) || (hi == 4'h0));

endmodule

// File: rtl/baser_257b_decoder.sv
// 256b/257b reverse transcoder: one 257b block in, four 66b blocks out over four cycles.
// Define BASER_DEC_INV_COUNT_EN to build the invalid-block counter on o_inv_count.
module baser_257b_decoder
  import baser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int TC_WIDTH   = 257
) (
  input  logic                            clk,
  input  logic                            i_rst,
  input  logic [TC_WIDTH-1:0]             i_rx_coded,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [DATA_WIDTH+HDR_WIDTH-1:0] o_rx_block,
  output logic                            o_valid,
  output logic [31:0]                     o_inv_count
);

  localparam int BW = DATA_WIDTH + HDR_WIDTH;

  state_t             state, state_nxt;
  logic               accept;
  logic [3:0][BW-1:0] dec, blk_q;
  logic [BW-1:0]      cur_blk;
  logic               dec_inv;

  baser_257b_unpack #(
    .DATA_WIDTH (DATA_WIDTH),
    .HDR_WIDTH  (HDR_WIDTH),
    .TC_WIDTH   (TC_WIDTH)
  ) u_unpack (
    .coded  (i_rx_coded),
    .blocks (dec),
    .inv    (dec_inv)
  );

  always_comb begin
    o_ready   = !i_rst && ((state == IDLE) || (state == OUT3));
    accept    = i_valid && o_ready;
    state_nxt = state;
    cur_blk   = blk_q[0];
    case (state)
      IDLE: if (accept) state_nxt = OUT0;
      OUT0: state_nxt = OUT1;
      OUT1: begin
        state_nxt = OUT2;
        cur_blk   = blk_q[1];
      end
      OUT2: begin
        state_nxt = OUT3;
        cur_blk   = blk_q[2];
      end
      OUT3: begin
        state_nxt = accept ? OUT0 : IDLE;
        cur_blk   = blk_q[3];
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register trails the state by one edge, so block k shows while in OUT(k+1)
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      blk_q      <= '0;
      o_valid    <= 1'b0;
      o_rx_block <= '0;
    end else begin
      state   <= state_nxt;
      o_valid <= (state != IDLE);
      if (state != IDLE) o_rx_block <= cur_blk;
      if (accept) blk_q <= dec_inv ? {4{ERR_BLOCK}} : dec;
    end
  end

`ifdef BASER_DEC_INV_COUNT_EN
  logic [31:0] inv_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      inv_cnt <= '0;
    end else if (accept && dec_inv && (inv_cnt != '1)) begin
      inv_cnt <= inv_cnt + 32'd1;
    end
  end

  assign o_inv_count = inv_cnt;
`else
  assign o_inv_count = '0;
`endif

endmodule
